// File: rtl/in_port_fifo.sv
// in_port_fifo: CPU-side input port. An external device pushes words through a
// valid/ready handshake into a small show-ahead FIFO. The datapath reads the
// head word and pops it with a one-cycle read pulse. Sticky overrun/underrun
// flags record protocol violations on either side.
module in_port_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     clr,
  input  logic [DATA_W-1:0]        ext_data,
  input  logic                     ext_valid,
  output logic                     ext_ready,
  input  logic                     inport_rd,
  output logic [DATA_W-1:0]        inport_data,
  output logic                     data_avail,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  output logic                     underrun,
  input  logic                     flag_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  // Handshake decode and show-ahead head word; full/empty come from count alone.
  always_comb begin
    ext_ready   = (count != FULL_COUNT);
    data_avail  = (count != '0);
    push        = ext_valid & ext_ready;
    pop         = inport_rd & data_avail;
    inport_data = data_avail ? mem[rd_ptr] : '0;
  end

  // Storage array: written on accepted push, never reset (invisible while empty).
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= ext_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at AW bits.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Sticky error flags; a new event on the same edge as flag_clr keeps the flag set.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (ext_valid && !ext_ready) begin
        overrun <= 1'b1;
      end else if (flag_clr) begin
        overrun <= 1'b0;
      end
      if (inport_rd && !data_avail) begin
        underrun <= 1'b1;
      end else if (flag_clr) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_in_port_fifo.sv
// Testbench for in_port_fifo: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the port.
module tb_in_port_fifo;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;

  logic              clock = 1'b0;
  logic              clr = 1'b1;
  logic [DATA_W-1:0] ext_data = '0;
  logic              ext_valid = 1'b0;
  logic              ext_ready;
  logic              inport_rd = 1'b0;
  logic [DATA_W-1:0] inport_data;
  logic              data_avail;
  logic [2:0]        count;
  logic              overrun;
  logic              underrun;
  logic              flag_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  logic              m_ov = 1'b0;
  logic              m_un = 1'b0;

  in_port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .clr        (clr),
    .ext_data   (ext_data),
    .ext_valid  (ext_valid),
    .ext_ready  (ext_ready),
    .inport_rd  (inport_rd),
    .inport_data(inport_data),
    .data_avail (data_avail),
    .count      (count),
    .overrun    (overrun),
    .underrun   (underrun),
    .flag_clr   (flag_clr)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DATA_W-1:0] exp_head();
    return (q.size() != 0) ? q[0] : '0;
  endfunction

  // Applies one cycle of stimulus and advances the model by the port's rules.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d,
                       input logic rd, input logic fc);
    bit full;
    bit empty;
    ext_valid = v;
    ext_data  = d;
    inport_rd = rd;
    flag_clr  = fc;
    @(posedge clock);
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    if (v && full) m_ov = 1'b1;
    else if (fc) m_ov = 1'b0;
    if (rd && empty) m_un = 1'b1;
    else if (fc) m_un = 1'b0;
    if (rd && !empty) void'(q.pop_front());
    if (v && !full) q.push_back(d);
    #1;
    ext_valid = 1'b0;
    inport_rd = 1'b0;
    flag_clr  = 1'b0;
  endtask

  task automatic async_clear();
    #2;
    clr = 1'b1;
    #1;
    q.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (2) @(posedge clock);
    #1 clr = 1'b0;
    cycle(1'b1, 32'h5A5A_0001, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 32'h5A5A_0002, 1'b0, 1'b0);
    async_clear();
    checks++;
    if (ext_ready !== 1'b1 || data_avail !== 1'b0 || count !== 3'd0 ||
        inport_data !== '0 || overrun !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset: ready=%b avail=%b count=%0d data=%h ov=%b un=%b, want 1 0 0 0 0 0",
               ext_ready, data_avail, count, inport_data, overrun, underrun);
    end
    #1 clr = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_push_pop();
    cycle(1'b1, 32'h1111_1111, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd1 || inport_data !== 32'h1111_1111) begin
      errors++;
      $display("FAIL push1: count=%0d data=%h, want 1 11111111", count, inport_data);
    end
    cycle(1'b1, 32'h2222_2222, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd2 || inport_data !== 32'h1111_1111) begin
      errors++;
      $display("FAIL push2: count=%0d data=%h, want 2 11111111", count, inport_data);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (count !== 3'd1 || inport_data !== 32'h2222_2222) begin
      errors++;
      $display("FAIL pop1: count=%0d data=%h, want 1 22222222", count, inport_data);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'hA0 + i, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd4 || ext_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill: count=%0d ready=%b, want 4 0", count, ext_ready);
    end
    cycle(1'b1, 32'hFF, 1'b0, 1'b0);
    checks++;
    if (overrun !== 1'b1 || count !== 3'd4) begin
      errors++;
      $display("FAIL overrun: ov=%b count=%0d, want 1 4", overrun, count);
    end
    // Pop while full with valid high: push blocked this edge.
    cycle(1'b1, 32'hEE, 1'b1, 1'b0);
    checks++;
    if (count !== 3'd3 || inport_data !== 32'hA1) begin
      errors++;
      $display("FAIL pop_full: count=%0d data=%h, want 3 a1", count, inport_data);
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (inport_data !== 32'hA0 + i) begin
        errors++;
        $display("FAIL drain%0d: data=%h, want %h", i, inport_data, 32'hA0 + i);
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    checks++;
    if (data_avail !== 1'b0 || inport_data !== '0) begin
      errors++;
      $display("FAIL drained: avail=%b data=%h, want 0 0", data_avail, inport_data);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ov_clr: ov=%b, want 0", overrun);
    end
  endtask

  task automatic test_wrap();
    cycle(1'b1, 32'hB0, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      checks++;
      if (inport_data !== 32'hB0 + i - 1) begin
        errors++;
        $display("FAIL wrap_head%0d: data=%h, want %h", i, inport_data, 32'hB0 + i - 1);
      end
      cycle(1'b1, 32'hB0 + i, 1'b1, 1'b0);
      checks++;
      if (count !== 3'd1) begin
        errors++;
        $display("FAIL wrap_count%0d: count=%0d, want 1", i, count);
      end
    end
    checks++;
    if (inport_data !== 32'hB6) begin
      errors++;
      $display("FAIL wrap_last: data=%h, want b6", inport_data);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_underrun();
    cycle(1'b1, 32'hC0, 1'b1, 1'b0);
    checks++;
    if (underrun !== 1'b1 || count !== 3'd1 || inport_data !== 32'hC0) begin
      errors++;
      $display("FAIL underrun: un=%b count=%0d data=%h, want 1 1 c0", underrun, count, inport_data);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (underrun !== 1'b0 || count !== 3'd1) begin
      errors++;
      $display("FAIL un_clr: un=%b count=%0d, want 0 1", underrun, count);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    // Event and clear on the same edge: set wins.
    cycle(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL un_setwins: un=%b, want 1", underrun);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_clr_mid();
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hD8 + i, 1'b0, 1'b0);
    async_clear();
    checks++;
    if (count !== 3'd0 || data_avail !== 1'b0 || ext_ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_mid: count=%0d avail=%b ready=%b, want 0 0 1", count, data_avail, ext_ready);
    end
    #1 clr = 1'b0;
    @(negedge clock);
    cycle(1'b1, 32'hD0, 1'b0, 1'b0);
    checks++;
    if (inport_data !== 32'hD0 || count !== 3'd1) begin
      errors++;
      $display("FAIL clr_push: data=%h count=%0d, want d0 1", inport_data, count);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 8);
      checks++;
      if (count !== 3'(q.size()) || ext_ready !== (q.size() != DEPTH) ||
          data_avail !== (q.size() != 0) || inport_data !== exp_head() ||
          overrun !== m_ov || underrun !== m_un) begin
        errors++;
        $display("FAIL random%0d: count=%0d ready=%b avail=%b data=%h ov=%b un=%b, want %0d %b %b %h %b %b",
                 n, count, ext_ready, data_avail, inport_data, overrun, underrun,
                 q.size(), q.size() != DEPTH, q.size() != 0, exp_head(), m_ov, m_un);
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overrun();
    test_wrap();
    test_underrun();
    test_clr_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
